ldpc_row_assembler: RTL and testbench

LDPC_ROW_ASSEMBLER -- requirements
Module: ldpc_row_assembler

---
 rtl/ldpc_row_assembler.sv | 108 ++++++++++
 tb/tb_ldpc_row_assembler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_row_assembler.sv
// Serial-to-row assembler: packs 7 framed message bytes into one row and
// double-buffers rows (ping-pong) ahead of the row-to-column stage.
module ldpc_row_assembler #(
  parameter int ROW_LEN = 7,
  parameter int DATA_W  = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data_0,
  output logic [DATA_W-1:0] o_data_1,
  output logic [DATA_W-1:0] o_data_2,
  output logic [DATA_W-1:0] o_data_3,
  output logic [DATA_W-1:0] o_data_4,
  output logic [DATA_W-1:0] o_data_5,
  output logic [DATA_W-1:0] o_data_6,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_error,
  output logic [7:0]        o_err_count
);

  localparam int IDX_W = $clog2(ROW_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

  typedef logic [ROW_LEN-1:0][DATA_W-1:0] row_t;

  row_t [1:0]       bank_q, bank_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rdy_en_q, rdy_en_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic in_fire, out_fire, at_end, commit, frame_err;

  // rdy_en_q holds o_ready low until the first clock edge after reset release
  assign o_ready     = rdy_en_q & (cnt_q != 2'd2);
  assign o_valid     = (cnt_q != 2'd0);
  assign o_error     = err_q;
  assign o_err_count = err_cnt_q;
  assign o_data_0    = bank_q[rd_q][0];
  assign o_data_1    = bank_q[rd_q][1];
  assign o_data_2    = bank_q[rd_q][2];
  assign o_data_3    = bank_q[rd_q][3];
  assign o_data_4    = bank_q[rd_q][4];
  assign o_data_5    = bank_q[rd_q][5];
  assign o_data_6    = bank_q[rd_q][6];

  always_comb begin
    in_fire   = i_valid & o_ready;
    out_fire  = o_valid & i_ready;
    at_end    = (idx_q == LAST_IDX);
    commit    = in_fire & i_last & at_end;
    frame_err = in_fire & (i_last ^ at_end);

    bank_d    = bank_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rdy_en_d  = 1'b1;
    err_d     = frame_err;
    err_cnt_d = err_cnt_q;

    // bank[wr] is never the presented bank while a row is pending, so writes are safe
    if (in_fire && !frame_err) bank_d[wr_q][idx_q] = i_data;
    if (in_fire) idx_d = (commit || frame_err) ? '0 : idx_q + 1'b1;
    if (commit) wr_d = ~wr_q;
    if (out_fire) rd_d = ~rd_q;

    case ({commit, out_fire})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    if (frame_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bank_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      idx_q     <= '0;
      rdy_en_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      bank_q    <= bank_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rdy_en_q  <= rdy_en_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ldpc_row_assembler.sv
// Bench for ldpc_row_assembler: fixed vector table, directed corner sequences,
// and random traffic against a queue-based row model.
module tb_ldpc_row_assembler;

  logic       i_clock = 1'b0;
  logic       i_reset_n = 1'b1;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b0;
  logic       o_ready, o_valid, o_error;
  logic [7:0] o_data_0, o_data_1, o_data_2, o_data_3, o_data_4, o_data_5, o_data_6;
  logic [7:0] o_err_count;
  logic [7:0] dout [7];

  always #5 i_clock = ~i_clock;

  ldpc_row_assembler #(.ROW_LEN(7), .DATA_W(8)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_data(i_data), .i_valid(i_valid),
    .i_last(i_last), .o_ready(o_ready), .o_data_0(o_data_0), .o_data_1(o_data_1),
    .o_data_2(o_data_2), .o_data_3(o_data_3), .o_data_4(o_data_4), .o_data_5(o_data_5),
    .o_data_6(o_data_6), .o_valid(o_valid), .i_ready(i_ready), .o_error(o_error),
    .o_err_count(o_err_count)
  );

  assign dout[0] = o_data_0; assign dout[1] = o_data_1; assign dout[2] = o_data_2;
  assign dout[3] = o_data_3; assign dout[4] = o_data_4; assign dout[5] = o_data_5;
  assign dout[6] = o_data_6;

  // Reference model: FIFO of complete rows (depth 2) plus the partial row in progress
  typedef logic [6:0][7:0] row_t;
  row_t       rows [$];
  logic [7:0] part [$];
  logic [7:0] seen_d0 [$];
  bit         m_err = 0;
  int         m_cnt = 0;
  bit         m_rdy_en = 0;
  int         checks = 0, errors = 0;

  function automatic bit m_ready(); return m_rdy_en && rows.size() < 2; endfunction
  function automatic bit m_valid(); return rows.size() != 0; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("ready", o_ready, m_ready());
    chk("valid", o_valid, m_valid());
    chk("error", o_error, m_err);
    chk("err_count", o_err_count, m_cnt);
    if (m_valid())
      for (int k = 0; k < 7; k++) chk($sformatf("data_%0d", k), dout[k], rows[0][k]);
  endtask

  task automatic model_update();
    bit inf, outf, e;
    row_t r;
    if (!i_reset_n) begin
      rows.delete(); part.delete(); m_err = 0; m_cnt = 0; m_rdy_en = 0;
      return;
    end
    inf  = i_valid && m_ready();
    outf = m_valid() && i_ready;
    e    = 0;
    if (outf) begin
      seen_d0.push_back(rows[0][0]);
      rows.delete(0);
    end
    if (inf) begin
      if (i_last) begin
        if (part.size() == 6) begin
          for (int k = 0; k < 6; k++) r[k] = part[k];
          r[6] = i_data;
          rows.push_back(r);
        end else e = 1;
        part.delete();
      end else if (part.size() == 6) begin
        e = 1;
        part.delete();
      end else part.push_back(i_data);
    end
    m_err = e;
    if (e && m_cnt < 255) m_cnt++;
    m_rdy_en = 1;
  endtask

  task automatic drive_and_check(input logic v, input logic [7:0] d, input logic l, input logic r);
    i_valid = v; i_data = d; i_last = l; i_ready = r;
    @(negedge i_clock);
    model_check();
  endtask

  task automatic advance();
    @(posedge i_clock);
    model_update();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic r);
    bit fired;
    int g;
    fired = 0; g = 0;
    do begin
      drive_and_check(1'b1, d, l, r);
      fired = m_ready();
      advance();
      g++;
    end while (!fired && g < 200);
    chk("send_timeout", fired, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (rows.size() != 0 && g < 50) begin
      drive_and_check(1'b0, 8'h00, 1'b0, 1'b1);
      advance();
      g++;
    end
    chk("drain_timeout", rows.size(), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, o_valid, 0);
    chk({nm, "_ready"}, o_ready, 0);
    chk({nm, "_error"}, o_error, 0);
    chk({nm, "_errcnt"}, o_err_count, 0);
    for (int k = 0; k < 7; k++) chk($sformatf("%s_data_%0d", nm, k), dout[k], 0);
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic l; logic r;
    logic ev; logic er; logic ee; logic [7:0] ed0; logic [7:0] ed6; logic [7:0] ec;
  } vec_t;
  vec_t tbl [$];

  function automatic void add(input logic v, input logic [7:0] d, input logic l, input logic r,
                              input logic ev, input logic er, input logic ee,
                              input logic [7:0] ed0, input logic [7:0] ed6, input logic [7:0] ec);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.ev = ev; t.er = er; t.ee = ee; t.ed0 = ed0; t.ed6 = ed6; t.ec = ec;
    tbl.push_back(t);
  endfunction

  initial begin
    int nv;
    // Expected outputs are those seen in the same cycle, before the edge that samples the inputs
    for (int k = 0; k < 7; k++) add(1, 8'(8'h10 + k), k == 6, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0, 8'h10, 8'h16, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 8'(8'hA0 + k), k == 3, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) add(1, 8'(8'hB0 + k), k == 6, 1, 0, 1, k == 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 8'hB0, 8'hB6, 1);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0, 1);

    // Reset state and delayed ready after release
    #1 i_reset_n = 1'b0;
    #1 chk_zero("reset");
    advance();
    advance();
    i_reset_n = 1'b1;
    drive_and_check(0, 0, 0, 0);
    chk("ready_after_release", o_ready, 0);
    advance();

    // Vector table: basic row, short-row error, recovery row
    for (int i = 0; i < tbl.size(); i++) begin
      drive_and_check(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      chk($sformatf("tv%0d_valid", i), o_valid, tbl[i].ev);
      chk($sformatf("tv%0d_ready", i), o_ready, tbl[i].er);
      chk($sformatf("tv%0d_error", i), o_error, tbl[i].ee);
      chk($sformatf("tv%0d_errcnt", i), o_err_count, tbl[i].ec);
      if (tbl[i].ev) begin
        chk($sformatf("tv%0d_d0", i), dout[0], tbl[i].ed0);
        chk($sformatf("tv%0d_d6", i), dout[6], tbl[i].ed6);
      end
      advance();
    end

    // Backpressure: two rows fill both banks, third row stalls at its first byte
    for (int k = 0; k < 7; k++) send_byte(8'(8'h00 + k), k == 6, 0);
    for (int k = 0; k < 7; k++) send_byte(8'(8'h20 + k), k == 6, 0);
    for (int c = 0; c < 5; c++) begin
      drive_and_check(1, 8'h40, 0, 0);
      chk("bp_ready_low", o_ready, 0);
      chk("bp_valid", o_valid, 1);
      chk("bp_hold_d0", dout[0], 8'h00);
      advance();
    end
    seen_d0.delete();
    for (int k = 0; k < 7; k++) send_byte(8'(8'h40 + k), k == 6, 1);
    drain();
    chk("bp_order_n", seen_d0.size(), 3);
    if (seen_d0.size() == 3) begin
      chk("bp_order_0", seen_d0[0], 8'h00);
      chk("bp_order_1", seen_d0[1], 8'h20);
      chk("bp_order_2", seen_d0[2], 8'h40);
    end

    // Continuous stream of 10 rows with consumer always ready
    nv = 0;
    for (int i = 0; i < 70; i++) begin
      drive_and_check(1, 8'(i), (i % 7) == 6, 1);
      chk("stream_ready", o_ready, 1);
      if (o_valid) nv++;
      advance();
    end
    drive_and_check(0, 0, 0, 1);
    if (o_valid) nv++;
    advance();
    chk("stream_rows", nv, 10);

    // Missing last on 7th byte, then saturate the error counter
    for (int k = 0; k < 7; k++) send_byte(8'(8'h60 + k), 0, 1);
    drive_and_check(0, 0, 0, 1);
    chk("miss_last_err", o_error, 1);
    chk("miss_last_novalid", o_valid, 0);
    advance();
    drive_and_check(0, 0, 0, 1);
    chk("err_pulse_end", o_error, 0);
    advance();
    for (int i = 0; i < 300; i++) send_byte(8'hEE, 1, 1);
    drive_and_check(0, 0, 0, 1);
    chk("err_saturate", o_err_count, 8'hFF);
    advance();

    // Reset with one row pending and a partial row in flight
    for (int k = 0; k < 7; k++) send_byte(8'(8'h70 + k), k == 6, 0);
    for (int k = 0; k < 4; k++) send_byte(8'(8'h80 + k), 0, 0);
    i_valid = 0;
    i_reset_n = 1'b0;
    #1 chk_zero("midrst");
    advance();
    i_reset_n = 1'b1;
    drive_and_check(0, 0, 0, 0);
    advance();
    for (int k = 0; k < 7; k++) send_byte(8'(8'h50 + k), k == 6, 0);
    drive_and_check(0, 0, 0, 0);
    chk("rst_row_valid", o_valid, 1);
    chk("rst_row_d0", dout[0], 8'h50);
    chk("rst_row_d6", dout[6], 8'h56);
    advance();
    drain();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic v, l, r;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : (part.size() == 6);
      r = ($urandom_range(0, 2) != 0);
      drive_and_check(v, 8'($urandom_range(0, 255)), l, r);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
